shift_sipo_loader: RTL and testbench

- Serial-in, parallel-out loader that sits directly upstream of the combinational shift stage.
- Collects a WIDTH-bit operand one bit per qualified cycle, then presents it on data_out with a valid/ready handshake; the shift stage consumes data_out as its operand.
- Small FSM plus bit counter, with holding under backpressure.

---
 rtl/shift_sipo_loader_if.sv | 26 ++
 rtl/shift_sipo_loader.sv | 147 ++++++++++++++
 tb/tb_shift_sipo_loader.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/shift_sipo_loader_if.sv
// Handshake/data bundle for shift_sipo_loader.
//   master : drives start, clr, sin, sin_valid, out_ready; observes results
//   slave  : the loader itself (data_out, out_valid, busy, parity_err)
interface shift_sipo_loader_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             clr;
   logic             sin;
   logic             sin_valid;
   logic             out_ready;
   logic [WIDTH-1:0] data_out;
   logic             out_valid;
   logic             busy;
   logic             parity_err;

   modport master (
      output start, clr, sin, sin_valid, out_ready,
      input  data_out, out_valid, busy, parity_err
   );

   modport slave (
      input  start, clr, sin, sin_valid, out_ready,
      output data_out, out_valid, busy, parity_err
   );
endinterface

// File: rtl/shift_sipo_loader.sv
// Serial-in, parallel-out operand loader feeding the shift stage.
// Collects WIDTH bits (one per sin_valid cycle in SHIFT), then presents the
// word on data_out with out_valid until out_ready accepts it.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   bus.start  begin capture (IDLE, or HOLD together with out_ready)
//   bus.clr    synchronous abort to IDLE, clears outputs
//   bus.sin / bus.sin_valid   serial data and its qualifier
//   bus.out_ready             consumer accepts data_out
//   bus.data_out / bus.out_valid / bus.busy / bus.parity_err
// Parameters: WIDTH (2..32), LSB_FIRST (0: first bit -> MSB, 1: first bit -> LSB)
// Build option: define SIPO_PARITY_EN to accept a trailing even-parity bit
// and report a mismatch on parity_err; otherwise parity_err is tied low.
module shift_sipo_loader #(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   shift_sipo_loader_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);
`ifdef SIPO_PARITY_EN
   localparam int LAST = WIDTH;       // index of the trailing parity bit
`else
   localparam int LAST = WIDTH - 1;
`endif
   localparam logic [CW-1:0] LAST_CNT = CW'(LAST);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [WIDTH-1:0] shifted;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ov_q, ov_d;
`ifdef SIPO_PARITY_EN
   logic             perr_q, perr_d;
`endif

   always_comb begin
      if (LSB_FIRST) shifted = {bus.sin, sreg_q[WIDTH-1:1]};
      else           shifted = {sreg_q[WIDTH-2:0], bus.sin};
   end

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      dout_d  = dout_q;
      ov_d    = ov_q;
`ifdef SIPO_PARITY_EN
      perr_d  = perr_q;
`endif
      if (bus.clr) begin
         state_d = IDLE;
         sreg_d  = '0;
         cnt_d   = '0;
         dout_d  = '0;
         ov_d    = 1'b0;
`ifdef SIPO_PARITY_EN
         perr_d  = 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  state_d = SHIFT;
                  sreg_d  = '0;
                  cnt_d   = '0;
               end
            end
            SHIFT: begin
               if (bus.sin_valid) begin
                  if (cnt_q == LAST_CNT) begin
                     state_d = HOLD;
                     ov_d    = 1'b1;
`ifdef SIPO_PARITY_EN
                     // final bit is parity: word is already complete in sreg
                     dout_d  = sreg_q;
                     perr_d  = (^sreg_q) ^ bus.sin;
`else
                     dout_d  = shifted;
`endif
                  end else begin
                     sreg_d = shifted;
                     cnt_d  = cnt_q + CW'(1);
                  end
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  ov_d = 1'b0;
`ifdef SIPO_PARITY_EN
                  perr_d = 1'b0;
`endif
                  if (bus.start) begin
                     state_d = SHIFT;
                     sreg_d  = '0;
                     cnt_d   = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         dout_q  <= '0;
         ov_q    <= 1'b0;
`ifdef SIPO_PARITY_EN
         perr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         ov_q    <= ov_d;
`ifdef SIPO_PARITY_EN
         perr_q  <= perr_d;
`endif
      end
   end

   assign bus.data_out  = dout_q;
   assign bus.out_valid = ov_q;
   assign bus.busy      = (state_q == SHIFT);
`ifdef SIPO_PARITY_EN
   assign bus.parity_err = perr_q;
`else
   assign bus.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_shift_sipo_loader.sv
// Bench for shift_sipo_loader: one MSB-first and one LSB-first instance
// driven by the same stimulus; expected words are built from the list of
// accepted bits.
module tb_shift_sipo_loader;
   localparam int W = 4;
`ifdef SIPO_PARITY_EN
   localparam int NB  = W + 1;
   localparam bit PAR = 1'b1;
`else
   localparam int NB  = W;
   localparam bit PAR = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0, clr = 1'b0, sin = 1'b0, sin_valid = 1'b0, out_ready = 1'b0;

   int vectors = 0;
   int fails   = 0;

   // reference state
   logic [W-1:0] exp_m = '0, exp_l = '0;
   logic         exp_p = 1'b0;

   always #5 clk = ~clk;

   shift_sipo_loader_if #(.WIDTH(W)) if_msb ();
   shift_sipo_loader_if #(.WIDTH(W)) if_lsb ();

   assign if_msb.start = start;     assign if_lsb.start = start;
   assign if_msb.clr = clr;         assign if_lsb.clr = clr;
   assign if_msb.sin = sin;         assign if_lsb.sin = sin;
   assign if_msb.sin_valid = sin_valid; assign if_lsb.sin_valid = sin_valid;
   assign if_msb.out_ready = out_ready; assign if_lsb.out_ready = out_ready;

   shift_sipo_loader #(.WIDTH(W), .LSB_FIRST(1'b0)) u_msb (.clk(clk), .rst(rst), .bus(if_msb));
   shift_sipo_loader #(.WIDTH(W), .LSB_FIRST(1'b1)) u_lsb (.clk(clk), .rst(rst), .bus(if_lsb));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic eov, input logic ebusy);
      chk({tag, ".msb.out_valid"}, 32'(if_msb.out_valid), 32'(eov));
      chk({tag, ".msb.busy"},      32'(if_msb.busy),      32'(ebusy));
      chk({tag, ".msb.data_out"},  32'(if_msb.data_out),  32'(exp_m));
      chk({tag, ".msb.parity"},    32'(if_msb.parity_err), 32'(eov & exp_p));
      chk({tag, ".lsb.out_valid"}, 32'(if_lsb.out_valid), 32'(eov));
      chk({tag, ".lsb.busy"},      32'(if_lsb.busy),      32'(ebusy));
      chk({tag, ".lsb.data_out"},  32'(if_lsb.data_out),  32'(exp_l));
      chk({tag, ".lsb.parity"},    32'(if_lsb.parity_err), 32'(eov & exp_p));
   endtask

   // bits[i] is the i-th bit sent; par is the trailing parity bit (parity builds only)
   task automatic capture(input string tag, input logic [31:0] bits, input logic par,
                          input int glo, input int ghi, input int hold_cycles,
                          input bit chain, input bit in_shift, input bit stay_hold);
      if (!in_shift) begin
         start = 1'b1; sin_valid = 1'b0; out_ready = 1'($urandom);
         @(negedge clk);
         start = 1'b0;
         chk_all({tag, ".start"}, 1'b0, 1'b1);
      end
      for (int i = 0; i < NB; i++) begin
         int g;
         g = int'($urandom_range(ghi, glo));
         for (int k = 0; k < g; k++) begin
            sin = 1'($urandom); sin_valid = 1'b0; start = 1'($urandom);
            @(negedge clk);
            chk_all({tag, ".gap"}, 1'b0, 1'b1);
         end
         sin = (i < W) ? bits[i] : par;
         sin_valid = 1'b1; start = 1'($urandom);
         @(negedge clk);
         sin_valid = 1'b0; start = 1'b0;
         if (i < NB - 1) begin
            chk_all({tag, ".bit"}, 1'b0, 1'b1);
         end else begin
            for (int j = 0; j < W; j++) begin
               exp_m[W-1-j] = bits[j];
               exp_l[j]     = bits[j];
            end
            exp_p = PAR ? ((^bits[W-1:0]) ^ par) : 1'b0;
            chk_all({tag, ".done"}, 1'b1, 1'b0);
         end
      end
      for (int k = 0; k < hold_cycles; k++) begin
         out_ready = 1'b0; start = 1'($urandom); sin_valid = 1'($urandom); sin = 1'($urandom);
         @(negedge clk);
         chk_all({tag, ".hold"}, 1'b1, 1'b0);
      end
      start = 1'b0; sin_valid = 1'b0;
      if (!stay_hold) begin
         out_ready = 1'b1; start = chain;
         @(negedge clk);
         out_ready = 1'b0; start = 1'b0;
         chk_all({tag, ".accept"}, 1'b0, chain);
      end
   endtask

   task automatic send_two_bits(input string tag);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         sin = 1'b1; sin_valid = 1'b1;
         @(negedge clk);
         sin_valid = 1'b0;
         chk_all(tag, 1'b0, 1'b1);
      end
   endtask

   initial begin
      bit chain_prev;
      #1;
      chk_all("reset", 1'b0, 1'b0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_all("idle", 1'b0, 1'b0);

      // idle ignores sin_valid/out_ready
      sin_valid = 1'b1; sin = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      sin_valid = 1'b0; out_ready = 1'b0;
      chk_all("idle_ignore", 1'b0, 1'b0);

      capture("basic_1100", 32'b0011, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      capture("gaps_1100",  32'b0011, 1'b0, 2, 2, 0, 1'b0, 1'b0, 1'b0);
      capture("bp_0000",    32'b0000, 1'b0, 0, 0, 5, 1'b1, 1'b0, 1'b0);
      capture("chain_1010", 32'b0101, 1'b0, 0, 1, 0, 1'b0, 1'b1, 1'b0);

      // clr mid-capture with a nonzero word still on data_out
      send_two_bits("pre_clr");
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      exp_m = '0; exp_l = '0; exp_p = 1'b0;
      chk_all("clr", 1'b0, 1'b0);
      capture("after_clr_0011", 32'b1100, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

      // asynchronous reset mid-capture
      send_two_bits("pre_rst");
      #2 rst = 1'b1;
      #1;
      exp_m = '0; exp_l = '0; exp_p = 1'b0;
      chk_all("rst_mid_shift", 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // asynchronous reset while holding a word
      capture("pre_rst_hold", 32'b1011, 1'b1, 0, 0, 2, 1'b0, 1'b0, 1'b1);
      #2 rst = 1'b1;
      #1;
      exp_m = '0; exp_l = '0; exp_p = 1'b0;
      chk_all("rst_in_hold", 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      capture("after_rst_0011", 32'b1100, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

      capture("par_ok",  32'b0011, 1'b0, 0, 0, 1, 1'b0, 1'b0, 1'b0);
      capture("par_bad", 32'b0011, 1'b1, 0, 0, 1, 1'b0, 1'b0, 1'b0);

      chain_prev = 1'b0;
      for (int n = 0; n < 24; n++) begin
         bit ch;
         ch = (n == 23) ? 1'b0 : 1'($urandom);
         capture("rand", $urandom, 1'($urandom), 0, 2, int'($urandom_range(3, 0)),
                 ch, chain_prev, 1'b0);
         chain_prev = ch;
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule
